// File: rtl/cfg_defs.sv
// Shared definitions for the fabric configuration loader: state encodings and
// default geometry of the serial configuration frame.
package cfg_defs;

  localparam int             CFG_W_DEF        = 116;
  localparam int             SYNC_W_DEF       = 8;
  localparam logic [7:0]     SYNC_WORD_DEF    = 8'hA5;
  localparam int             SYNC_TIMEOUT_DEF = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SYNC   = ST_SYNC,
    LOAD   = ST_LOAD,
    PARITY = ST_PARITY,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE,
    ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/cfg_sync_detect.sv
// Sync-pattern hunter: shifts candidate bits, counts them, and flags a match or
// a search timeout based on the values the current bit would produce.
module cfg_sync_detect #(
  parameter int              SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int              SYNC_TIMEOUT = 64,
  localparam int             CNT_W        = $clog2(SYNC_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic match,
  output logic timeout
);

  logic [SYNC_W-1:0] sr_reg, sr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Flags look at the post-shift values so the FSM can leave SYNC on the same edge.
  always_comb begin
    sr_next  = {sr_reg[SYNC_W-2:0], bit_in};
    cnt_next = cnt_reg + CNT_W'(1);
    match    = enable && (sr_next == SYNC_WORD) && (cnt_next >= CNT_W'(SYNC_W));
    timeout  = enable && (cnt_next == CNT_W'(SYNC_TIMEOUT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (clear) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (enable) begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader: hunts for the sync word, shifts in the payload
// and parity bit, and commits the word to the fabric only when parity is even.
module cfg_loader
  import cfg_defs::*;
#(
  parameter int                CFG_W        = CFG_W_DEF,
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int                SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] bitstream,
  output logic             fabric_en,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int LCNT_W = $clog2(CFG_W);

  state_t             state_reg, state_next;
  logic [CFG_W-1:0]   shadow_reg, shadow_next;
  logic [CFG_W-1:0]   bitstream_reg, bitstream_next;
  logic [LCNT_W-1:0]  lcnt_reg, lcnt_next;
  logic               pacc_reg, pacc_next;
  logic               pbit_reg, pbit_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic               fen_reg, fen_next;

  logic accept;
  logic start_ok;
  logic sync_en;
  logic sync_match;
  logic sync_timeout;

  assign cfg_ready = (state_reg == SYNC) || (state_reg == LOAD) || (state_reg == PARITY);
  assign accept    = cfg_valid && cfg_ready;
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign sync_en   = (state_reg == SYNC) && accept;

  cfg_sync_detect #(
    .SYNC_W       (SYNC_W),
    .SYNC_WORD    (SYNC_WORD),
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .enable  (sync_en),
    .bit_in  (cfg_bit),
    .match   (sync_match),
    .timeout (sync_timeout)
  );

  always_comb begin
    state_next     = state_reg;
    shadow_next    = shadow_reg;
    bitstream_next = bitstream_reg;
    lcnt_next      = lcnt_reg;
    pacc_next      = pacc_reg;
    pbit_next      = pbit_reg;
    done_next      = done_reg;
    err_next       = err_reg;
    fen_next       = fen_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = SYNC;
          done_next  = 1'b0;
          err_next   = 1'b0;
          fen_next   = 1'b0;
          lcnt_next  = '0;
          pacc_next  = 1'b0;
        end
      end
      SYNC: begin
        if (sync_match) begin
          state_next = LOAD;
        end else if (sync_timeout) begin
          state_next = ERROR;
          err_next   = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          shadow_next = {shadow_reg[CFG_W-2:0], cfg_bit};
          pacc_next   = pacc_reg ^ cfg_bit;
          if (lcnt_reg == LCNT_W'(CFG_W - 1)) begin
            lcnt_next  = '0;
            state_next = PARITY;
          end else begin
            lcnt_next = lcnt_reg + LCNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (accept) begin
          pbit_next  = cfg_bit;
          state_next = CHECK;
        end
      end
      CHECK: begin
        // Even parity over payload plus parity bit is the only path that touches bitstream.
        if ((pacc_reg ^ pbit_reg) == 1'b0) begin
          bitstream_next = shadow_reg;
          done_next      = 1'b1;
          fen_next       = 1'b1;
          state_next     = DONE;
        end else begin
          err_next   = 1'b1;
          state_next = ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      bitstream_reg <= '0;
      lcnt_reg      <= '0;
      pacc_reg      <= 1'b0;
      pbit_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      fen_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shadow_reg    <= shadow_next;
      bitstream_reg <= bitstream_next;
      lcnt_reg      <= lcnt_next;
      pacc_reg      <= pacc_next;
      pbit_reg      <= pbit_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      fen_reg       <= fen_next;
    end
  end

  assign bitstream = bitstream_reg;
  assign cfg_done  = done_reg;
  assign cfg_err   = err_reg;
  assign fabric_en = fen_reg;

endmodule

// File: tb/tb_cfg_loader.sv
// Randomized self-checking bench for cfg_loader; expectations come from a
// frame-level model of sync search, payload ordering and even parity.
module tb_cfg_loader;
  import cfg_defs::*;

  localparam int W  = CFG_W_DEF;
  localparam int SW = SYNC_W_DEF;
  localparam int TO = SYNC_TIMEOUT_DEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cfg_bit;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] bitstream;
  logic         fabric_en;
  logic         cfg_done;
  logic         cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_bs;

  cfg_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .bitstream (bitstream),
    .fabric_en (fabric_en),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of the sync hunt: position (1-based) of lock or timeout in a bit stream.
  function automatic int sync_outcome(input bit q[$], output bit locked);
    logic [SW-1:0] win = '0;
    locked = 1'b0;
    for (int n = 1; n <= q.size(); n++) begin
      win = {win[SW-2:0], q[n-1]};
      if (n >= SW && win == SYNC_WORD_DEF) begin
        locked = 1'b1;
        return n;
      end
      if (n == TO) return n;
    end
    return -1;
  endfunction

  task automatic send_bit(input logic b);
    int gap;
    gap = $urandom_range(0, 3);
    cfg_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    for (int w = 0; w < 16 && !cfg_ready; w++) begin @(posedge clk); #1; end
    if (!cfg_ready) begin
      chk("ready_wait", 1'b0, 1'b1);
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ready", cfg_ready, 1'b1);
    chk("start_done",  cfg_done,  1'b0);
    chk("start_err",   cfg_err,   1'b0);
    chk("start_fen",   fabric_en, 1'b0);
    chk("start_bs",    bitstream, exp_bs);
  endtask

  task automatic send_sync_word();
    logic [SW-1:0] s;
    s = SYNC_WORD_DEF;
    for (int i = SW - 1; i >= 0; i--) send_bit(s[i]);
  endtask

  // Payload is sent MSB first; optionally pulses start before payload bit pulse_at.
  task automatic send_frame(input logic [W-1:0] p, input logic par, input int pulse_at);
    for (int i = 0; i < W; i++) begin
      if (i == pulse_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ignored_ready", cfg_ready, 1'b1);
      end
      send_bit(p[W-1-i]);
    end
    send_bit(par);
    chk("check_ready", cfg_ready, 1'b0);
    chk("check_done",  cfg_done,  1'b0);
    chk("check_bs",    bitstream, exp_bs);
    @(posedge clk); #1;
  endtask

  task automatic expect_commit(input logic [W-1:0] p, input string name);
    exp_bs = p;
    chk({name, "_bs"},    bitstream, exp_bs);
    chk({name, "_done"},  cfg_done,  1'b1);
    chk({name, "_fen"},   fabric_en, 1'b1);
    chk({name, "_err"},   cfg_err,   1'b0);
    chk({name, "_ready"}, cfg_ready, 1'b0);
    $display("load %s: committed %h", name, bitstream);
  endtask

  task automatic expect_reject(input string name);
    chk({name, "_bs"},   bitstream, exp_bs);
    chk({name, "_done"}, cfg_done,  1'b0);
    chk({name, "_fen"},  fabric_en, 1'b0);
    chk({name, "_err"},  cfg_err,   1'b1);
    $display("load %s: rejected, bitstream kept %h", name, bitstream);
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = 1'($urandom);
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat, p2;
    bit q[$];
    bit locked;
    int pos;

    exp_bs    = '0;
    reset     = 1'b0;
    start     = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;

    // Reset held with random activity on the inputs.
    for (int c = 0; c < 6; c++) begin
      start     = 1'($urandom);
      cfg_bit   = 1'($urandom);
      cfg_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_ready", cfg_ready, 1'b0);
      chk("rst_out",   {bitstream, fabric_en, cfg_done, cfg_err}, '0);
    end
    start = 1'b0; cfg_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", cfg_ready, 1'b0);
    $display("reset: outputs idle");

    // Good load with the i%3 pattern and a start pulse mid-payload.
    for (int i = 0; i < W; i++) pat[W-1-i] = (i % 3 == 0);
    do_start();
    send_sync_word();
    send_frame(pat, ^pat, 20);
    expect_commit(pat, "good");
    repeat (3) begin cfg_valid = 1'b1; @(posedge clk); #1; end
    cfg_valid = 1'b0;
    chk("done_hold_ready", cfg_ready, 1'b0);
    chk("done_hold_bs", bitstream, exp_bs);

    // Bad parity on a different payload.
    p2 = ~pat;
    do_start();
    send_sync_word();
    send_frame(p2, ~(^p2), -1);
    expect_reject("badpar");

    // Fixed sync hunt: 1,1,0,1 then the sync word.
    q = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    pos = sync_outcome(q, locked);
    chk("model_lock12", 32'(pos), 32'd12);
    do_start();
    for (int i = 0; i < pos; i++) send_bit(q[i]);
    p2 = rand_payload();
    send_frame(p2, ^p2, -1);
    expect_commit(p2, "sync1101");

    // Randomized sync hunts with random noise before the sync word.
    for (int t = 0; t < 3; t++) begin
      logic [SW-1:0] s;
      q = {};
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) q.push_back(1'($urandom));
      s = SYNC_WORD_DEF;
      for (int i = SW - 1; i >= 0; i--) q.push_back(s[i]);
      pos = sync_outcome(q, locked);
      do_start();
      for (int i = 0; i < pos; i++) send_bit(q[i]);
      p2 = rand_payload();
      if (locked) begin
        send_frame(p2, ^p2, -1);
        expect_commit(p2, "randsync");
      end else begin
        chk("randsync_model", 32'(locked), 32'd1);
      end
    end

    // Timeout: zeros only.
    q = {};
    for (int i = 0; i < TO; i++) q.push_back(1'b0);
    pos = sync_outcome(q, locked);
    chk("model_timeout", {31'(pos), locked}, {31'(TO), 1'b0});
    do_start();
    for (int i = 0; i < pos; i++) begin
      send_bit(q[i]);
      if (i == pos - 2) chk("pre_timeout_err", cfg_err, 1'b0);
    end
    chk("timeout_err",   cfg_err,   1'b1);
    chk("timeout_ready", cfg_ready, 1'b0);
    chk("timeout_fen",   fabric_en, 1'b0);
    cfg_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    cfg_valid = 1'b0;
    chk("timeout_hold_ready", cfg_ready, 1'b0);
    chk("timeout_bs", bitstream, exp_bs);
    $display("timeout: error after %0d zero bits", pos);

    // Sync word whose last bit is the final bit before timeout.
    q = {};
    for (int i = 0; i < TO - SW; i++) q.push_back(1'b0);
    begin
      logic [SW-1:0] s;
      s = SYNC_WORD_DEF;
      for (int i = SW - 1; i >= 0; i--) q.push_back(s[i]);
    end
    pos = sync_outcome(q, locked);
    chk("model_edge_lock", {31'(pos), locked}, {31'(TO), 1'b1});
    do_start();
    for (int i = 0; i < pos; i++) send_bit(q[i]);
    chk("edge_no_err", cfg_err,   1'b0);
    chk("edge_ready",  cfg_ready, 1'b1);
    p2 = rand_payload();
    send_frame(p2, ^p2, -1);
    expect_commit(p2, "edge");

    // Reset asserted at payload bit 50.
    do_start();
    send_sync_word();
    p2 = rand_payload();
    for (int i = 0; i < 50; i++) send_bit(p2[W-1-i]);
    #2 reset = 1'b0;
    #1;
    exp_bs = '0;
    chk("midrst_bs",    bitstream, exp_bs);
    chk("midrst_stat",  {fabric_en, cfg_done, cfg_err}, 3'b000);
    chk("midrst_ready", cfg_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", cfg_ready, 1'b0);
    chk("post_rst_bs",    bitstream, exp_bs);
    $display("midreset: returned to idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
